// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals shared by mem_arbiter and its environment.
// slave is the arbiter's view; master is the view of the IF/LSU/memory side driving it.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ack;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic                  ls_ack;
    logic [DATA_WIDTH-1:0] ls_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_req_valid;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_data_valid;

    logic                  busy;
    logic                  err;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_ack, ls_rdata,
        output mem_addr, mem_req_valid, mem_we, mem_wdata,
        input  mem_rdata, mem_data_valid,
        output busy, err
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_ack, ls_rdata,
        input  mem_addr, mem_req_valid, mem_we, mem_wdata,
        output mem_rdata, mem_data_valid,
        input  busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin IF/LSU arbiter for a single-port memory; 3 cycles req->ack, one access per 4 cycles.
// Requests are level-held, so none are lost while busy; MEM_ARB_TIMEOUT_EN adds a WAIT timeout flagged on err.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must lie in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_t;

    state_t                state_q,    state_d;
    req_t                  rr_last_q,  rr_last_d;
    req_t                  grant_q,    grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  we_q,       we_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0]            cnt_q,      cnt_d;
    logic                  err_q,      err_d;
`endif

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    // IF wins when alone, or when LS took the previous grant.
                    if (bus.if_req && (!bus.ls_req || rr_last_q == REQ_LS)) begin
                        grant_d = REQ_IF;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end else begin
                        grant_d = REQ_LS;
                        addr_d  = bus.ls_addr;
                        wdata_d = bus.ls_wdata;
                        we_d    = bus.ls_we;
                    end
                    rr_last_d = grant_d;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
                err_d   = 1'b0;
`endif
            end
            S_WAIT: begin
                if (bus.mem_data_valid) begin
                    if (grant_q == REQ_IF) begin
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        ls_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end
                    state_d = S_RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT_LIM) begin
                    if (grant_q == REQ_IF) begin
                        if_rdata_d = '0;
                    end else begin
                        ls_rdata_d = '0;
                    end
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_last_q  <= REQ_LS;
            grant_q    <= REQ_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Memory-side outputs are gated by ISSUE so they read zero in every other state.
    assign bus.mem_req_valid = (state_q == S_ISSUE);
    assign bus.mem_addr      = (state_q == S_ISSUE) ? addr_q  : '0;
    assign bus.mem_we        = (state_q == S_ISSUE) && we_q;
    assign bus.mem_wdata     = (state_q == S_ISSUE) ? wdata_q : '0;

    assign bus.if_ack   = (state_q == S_RESP) && (grant_q == REQ_IF);
    assign bus.ls_ack   = (state_q == S_RESP) && (grant_q == REQ_LS);
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.busy     = (state_q != S_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err      = (state_q == S_RESP) && err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency little-endian byte memory model.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    logic mem_stall;
    int   checks;
    int   passes;
    int   fails;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory answers the cycle after a request; mem_stall suppresses the completion.
    logic [7:0] mem [0:63];
    wire  [5:0] ma = bus.mem_addr[5:0];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
            mem[8]  <= 8'h11;
            mem[9]  <= 8'h22;
            mem[10] <= 8'h33;
            mem[11] <= 8'h44;
            bus.mem_data_valid <= 1'b0;
            bus.mem_rdata      <= '0;
        end else begin
            bus.mem_data_valid <= bus.mem_req_valid && !mem_stall;
            if (bus.mem_req_valid) begin
                bus.mem_rdata <= {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
                if (bus.mem_we) begin
                    mem[ma]        <= bus.mem_wdata[7:0];
                    mem[ma + 6'd1] <= bus.mem_wdata[15:8];
                    mem[ma + 6'd2] <= bus.mem_wdata[23:16];
                    mem[ma + 6'd3] <= bus.mem_wdata[31:24];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) begin
            passes = passes + 1;
        end else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b1;
        mem_stall    = 1'b0;
        checks       = 0;
        passes       = 0;
        fails        = 0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_if_ack",    bus.if_ack,        0);
        check("rst_ls_ack",    bus.ls_ack,        0);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        check("rst_mem_we",    bus.mem_we,        0);
        check("rst_busy",      bus.busy,          0);
        check("rst_err",       bus.err,           0);
        check("rst_if_rdata",  bus.if_rdata,      0);
        check("rst_ls_rdata",  bus.ls_rdata,      0);
        check("rst_mem_addr",  bus.mem_addr,      0);
        check("rst_mem_wdata", bus.mem_wdata,     0);
        reset = 1'b0;

        // Single IF read of 0x8
        bus.if_addr = 32'h8;
        bus.if_req  = 1'b1;
        check("if_n_busy", bus.busy, 0);
        tick();
        check("if_n1_valid", bus.mem_req_valid, 1);
        check("if_n1_addr",  bus.mem_addr,      32'h8);
        check("if_n1_we",    bus.mem_we,        0);
        check("if_n1_busy",  bus.busy,          1);
        tick();
        check("if_n2_valid", bus.mem_req_valid, 0);
        check("if_n2_addr",  bus.mem_addr,      0);
        check("if_n2_ack",   bus.if_ack,        0);
        tick();
        check("if_n3_ack",   bus.if_ack,   1);
        check("if_n3_rdata", bus.if_rdata, 32'h44332211);
        check("if_n3_lsack", bus.ls_ack,   0);
        check("if_n3_err",   bus.err,      0);
        bus.if_req = 1'b0;
        tick();
        check("if_n4_ack",   bus.if_ack,   0);
        check("if_n4_busy",  bus.busy,     0);
        check("if_n4_hold",  bus.if_rdata, 32'h44332211);

        // Load 0x4 before the store so the store's zero rdata is observable
        bus.ls_addr = 32'h4;
        bus.ls_we   = 1'b0;
        bus.ls_req  = 1'b1;
        repeat (3) tick();
        check("ld0_ack",   bus.ls_ack,   1);
        check("ld0_rdata", bus.ls_rdata, 32'h07060504);
        bus.ls_req = 1'b0;
        tick();

        // Store 0xDEADBEEF to 0x4
        bus.ls_we    = 1'b1;
        bus.ls_wdata = 32'hDEADBEEF;
        bus.ls_req   = 1'b1;
        tick();
        check("st_n1_we",    bus.mem_we,        1);
        check("st_n1_valid", bus.mem_req_valid, 1);
        check("st_n1_addr",  bus.mem_addr,      32'h4);
        check("st_n1_wdata", bus.mem_wdata,     32'hDEADBEEF);
        tick();
        check("st_n2_we",    bus.mem_we,    0);
        check("st_n2_wdata", bus.mem_wdata, 0);
        tick();
        check("st_n3_ack",   bus.ls_ack,   1);
        check("st_n3_rdata", bus.ls_rdata, 0);
        bus.ls_req = 1'b0;
        tick();

        // Load back 0x4
        bus.ls_we  = 1'b0;
        bus.ls_req = 1'b1;
        tick();
        check("ld1_n1_we", bus.mem_we, 0);
        repeat (2) tick();
        check("ld1_ack",   bus.ls_ack,   1);
        check("ld1_rdata", bus.ls_rdata, 32'hDEADBEEF);
        bus.ls_req = 1'b0;
        tick();

        // Contention from reset: grants IF, LS, IF, LS with acks 4 cycles apart
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        bus.if_addr = 32'h10;
        bus.ls_addr = 32'h20;
        bus.ls_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.ls_req  = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            check("rr_if_ack", bus.if_ack, (c == 3 || c == 11));
            check("rr_ls_ack", bus.ls_ack, (c == 7 || c == 15));
            if (c == 3)  check("rr_if_rdata", bus.if_rdata, 32'h13121110);
            if (c == 7)  check("rr_ls_rdata", bus.ls_rdata, 32'h23222120);
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        tick();
        check("rr_idle", bus.busy, 0);

        // Reset during WAIT of an IF access (rr_last becomes IF before the abort)
        bus.if_addr = 32'h8;
        bus.if_req  = 1'b1;
        repeat (2) tick();
        check("wr_wait_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("wr_async_busy",   bus.busy,          0);
        check("wr_async_valid",  bus.mem_req_valid, 0);
        check("wr_async_rdata",  bus.if_rdata,      0);
        check("wr_async_ack",    bus.if_ack,        0);
        tick();
        check("wr_hold_ack", bus.if_ack, 0);
        bus.ls_addr = 32'h20;
        bus.ls_req  = 1'b1;
        reset       = 1'b0;
        repeat (3) tick();
        check("wr_if_first",  bus.if_ack,   1);
        check("wr_ls_wait",   bus.ls_ack,   0);
        check("wr_if_rdata",  bus.if_rdata, 32'h44332211);
        bus.if_req = 1'b0;
        repeat (4) tick();
        check("wr_ls_ack",   bus.ls_ack,   1);
        check("wr_ls_rdata", bus.ls_rdata, 32'h23222120);
        bus.ls_req = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never completes: ack with err at N+7, then a normal access
        mem_stall   = 1'b1;
        bus.if_addr = 32'h8;
        bus.if_req  = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("to_ack", bus.if_ack, (c == 7));
            if (c == 7) begin
                check("to_err",   bus.err,      1);
                check("to_rdata", bus.if_rdata, 0);
            end
        end
        bus.if_req = 1'b0;
        mem_stall  = 1'b0;
        tick();
        bus.if_req = 1'b1;
        repeat (3) tick();
        check("to_next_ack",   bus.if_ack,   1);
        check("to_next_err",   bus.err,      0);
        check("to_next_rdata", bus.if_rdata, 32'h44332211);
        bus.if_req = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `Mem_top` memory model. It shares the memory between the instruction-fetch unit (read-only) and the load/store unit (read/write) using round-robin priority. It issues exactly one single-cycle memory request per grant and returns the result to the granted requester with a one-cycle acknowledge. It sits between the core's IF/LSU and the memory in the SoC simulation top; the top converts `mem_wdata`/`mem_rdata` to the memory's `Data` inout bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width; addresses pass through unchanged as byte addresses.
- `DATA_WIDTH`, 32: data width of all data ports.
- `TIMEOUT_CYCLES`, 16: WAIT-state limit in cycles; used only with `MEM_ARB_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all logic samples on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  fetch address; held stable while `if_req` is high.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` is valid in this cycle.
- `if_rdata`  out  DATA_WIDTH  fetched word.
- `ls_req`  in  1  load/store request; held high until `ls_ack`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  ADDR_WIDTH  load/store address.
- `ls_wdata`  in  DATA_WIDTH  store data.
- `ls_ack`  out  1  one-cycle pulse; `ls_rdata` is valid in this cycle.
- `ls_rdata`  out  DATA_WIDTH  load data; 0 for stores.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_req_valid`  out  1  memory request strobe; high for exactly one cycle per access.
- `mem_we`  out  1  memory write enable; high only in a store's ISSUE cycle. The top drives `Data` from `mem_wdata` only while this is high.
- `mem_wdata`  out  DATA_WIDTH  store data to memory.
- `mem_rdata`  in  DATA_WIDTH  `Data` bus as read by the top.
- `mem_data_valid`  in  1  memory completion flag.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  high together with an ack when the access timed out.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `if_req` or `ls_req` is high, select the granted requester, latch its address, write data and we into internal registers, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - With one requester, grant it.
  - With both requesting, grant the requester that did not receive the last grant.
  - The `rr_last` register updates on every grant; its reset value is LS, so IF wins the first contest.
- ISSUE:
  - Drive `mem_req_valid`=1, `mem_addr`, `mem_we`, and `mem_wdata` from the latched registers.
  - Go to WAIT.
- WAIT:
  - All memory outputs are 0.
  - When `mem_data_valid` is high, capture `mem_rdata` (or 0 for a store) into the granted requester's rdata register and go to RESP.
- RESP:
  - Pulse the granted requester's ack for one cycle and return to IDLE.
  - Requests are not sampled in RESP.
  - A requester must drop req in the cycle after its ack. A req still high in the following IDLE cycle is treated as a new access.
- Requests arriving while `busy` is high are not lost: req is level-held, so they are serviced from IDLE.
- The rdata outputs hold their last value between acks.
- Reset mid-access aborts it immediately:
  - No ack is issued.
  - The FSM returns to IDLE.
  - `rr_last` returns to LS.

## Timing
- Reset values:
  - `if_ack`, `ls_ack`, `mem_req_valid`, `mem_we`, `busy`, `err`: 0.
  - `if_rdata`, `ls_rdata`, `mem_addr`, `mem_wdata`: 0.
  - State: IDLE.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- Cycle-level sequence for a request first seen high in IDLE during cycle N:
  - Cycle N+1: ISSUE; `mem_req_valid` is high.
  - Cycle N+2: memory `data_valid` is high.
  - Cycle N+3: ack is high.
  - Cycle N+4: IDLE.
- Best-case latency is 3 cycles from req to ack. Throughput is one access per 4 cycles.
- The LSU access of a simultaneous pair is acked 4 cycles after the IF ack.

## Configuration
- Macro: `MEM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If `mem_data_valid` has not arrived when the counter reaches `TIMEOUT_CYCLES`, go to RESP with rdata=0 and `err`=1 during the ack.
  - A late `mem_data_valid` seen in IDLE is ignored.
- Undefined:
  - WAIT waits indefinitely.
  - No counter is present.
  - `err` is tied to 0.

## Test plan
- Single IF read, addr=0x8, memory bytes 0x8..0xB = 11,22,33,44 -> `mem_req_valid` high exactly one cycle, `if_ack` at N+3, `if_rdata`=0x44332211.
- LSU store addr=0x4, wdata=0xDEADBEEF, then load addr=0x4 -> store: `mem_we`=1 only in ISSUE and `ls_rdata`=0. Load: `ls_rdata` shows Mem[4] updated per the memory model.
- `if_req` and `ls_req` both high from reset and held -> grants IF, LS, IF, LS. Acks are 4 cycles apart and never coincide.
- Reset asserted in WAIT -> outputs 0 asynchronously, no ack, and `rr_last`=LS. After release, both requesting -> IF is granted first.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `mem_data_valid` forced 0 -> ack with `err`=1 and rdata=0 at N+7. Next access completes normally with `err`=0.
